vga_rx_monitor: RTL



---
 rtl/vga_rx_monitor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_monitor.sv
// Receive-side monitor for a VGA sync/colour stream: timing lock, pixel coordinates, frame checksum, probe capture.
// Optional blanking-colour check is built only when VGA_RX_BLANK_CHECK_EN is defined.
module vga_rx_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned H_ACT       = 640,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_valid,
  output logic [11:0] px_rgb,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic        err_hline,
  output logic        err_vframe,
  output logic [15:0] frame_sum,
  output logic        frame_done,
  output logic [11:0] probe_rgb,
  output logic        probe_stb,
  output logic        err_blank
);

  localparam logic [9:0] HT   = 10'(H_TOTAL);
  localparam logic [9:0] VT   = 10'(V_TOTAL);
  localparam logic [9:0] HS   = 10'(H_ACT_START);
  localparam logic [9:0] HE   = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0] VS   = 10'(V_ACT_START);
  localparam logic [9:0] VE   = 10'(V_ACT_START + V_ACT);
  localparam logic [9:0] CMAX = '1;
  localparam logic [2:0] LF   = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        hs_d, vs_line, bad;
  logic [9:0]  hcnt, vline;
  logic [2:0]  good;
  logic [15:0] acc;

  logic        hfall, fstart, len_bad, frame_ok, active, herr, verr, probe_hit;
  logic [9:0]  hpos, vline_inc, col, row;
  logic [11:0] rgb;

  always_comb begin
    hfall     = hs_d & ~hsync;
    fstart    = hfall & ~vsync & vs_line;
    hpos      = hfall ? '0 : hcnt;
    vline_inc = vline + 10'd1;
    rgb       = {r, g, b};
    col       = hpos - HS;
    row       = vline - VS;
    len_bad   = hfall & (hcnt != HT);
    frame_ok  = (vline_inc == VT);
    active    = (state == LOCKED) && (hpos >= HS) && (hpos < HE) &&
                (vline >= VS) && (vline < VE);
    // A saturated counter means hsync has gone missing; treat it as a bad line.
    herr      = (state == LOCKED) & (len_bad | (hcnt == CMAX));
    verr      = (state == LOCKED) & fstart & ~frame_ok;
    probe_hit = active & (col == probe_x) & (row == probe_y);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d        <= 1'b1;
      vs_line     <= 1'b1;
      hcnt        <= '0;
      vline       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      hs_d <= hsync;
      hcnt <= (hpos == CMAX) ? CMAX : hpos + 10'd1;
      if (hfall) begin
        line_len <= hcnt;
        vs_line  <= vsync;
        if (fstart) begin
          frame_lines <= vline_inc;
          vline       <= '0;
        end else begin
          vline <= (vline == CMAX) ? CMAX : vline_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      good       <= '0;
      bad        <= 1'b0;
      err_hline  <= 1'b0;
      err_vframe <= 1'b0;
    end else begin
      err_hline  <= 1'b0;
      err_vframe <= 1'b0;
      case (state)
        SEARCH: begin
          if (fstart) begin
            state <= MEASURE;
            good  <= '0;
            bad   <= 1'b0;
          end
        end
        MEASURE: begin
          // The line closed by the frame-start hsync still counts toward the frame ending here.
          if (fstart) begin
            bad <= 1'b0;
            if (!bad && !len_bad && frame_ok) begin
              good <= good + 3'd1;
              if (good + 3'd1 == LF) state <= LOCKED;
            end else begin
              good <= '0;
            end
          end else if (len_bad) begin
            bad <= 1'b1;
          end
        end
        LOCKED: begin
          err_hline  <= herr;
          err_vframe <= verr;
          if (herr | verr) state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_x       <= '0;
      px_y       <= '0;
      px_valid   <= 1'b0;
      px_rgb     <= '0;
      acc        <= '0;
      frame_sum  <= '0;
      frame_done <= 1'b0;
      probe_rgb  <= '0;
      probe_stb  <= 1'b0;
    end else begin
      px_valid <= active;
      if (active) begin
        px_x   <= col;
        px_y   <= row;
        px_rgb <= rgb;
      end
      probe_stb <= probe_hit;
      if (probe_hit) probe_rgb <= rgb;
      frame_done <= 1'b0;
      if ((state == LOCKED) && fstart && !verr) begin
        frame_sum  <= acc;
        frame_done <= 1'b1;
        acc        <= '0;
      end else if (herr | verr) begin
        acc <= '0;
      end else if (active) begin
        acc <= acc + 16'(rgb);
      end
    end
  end

`ifdef VGA_RX_BLANK_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_blank <= 1'b0;
    else        err_blank <= (state == LOCKED) & ~active & (rgb != '0);
  end
`else
  assign err_blank = 1'b0;
`endif

endmodule
